// File: rtl/axi_wdata_slave_pkg.sv
// rtl/axi_wdata_slave_pkg.sv - response codes, FSM encoding and defaults for axi_wdata_slave
package axi_wdata_slave_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BURST_LEN = 256;
    localparam int CNT_W         = 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/axi_wdata_slave_sync_fifo.sv
// rtl/axi_wdata_slave_sync_fifo.sv - power-of-2 synchronous FIFO with registered read port
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;
    logic [DATA_W-1:0] r_dout;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_level == FULL_LVL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_dout;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_dout <= r_mem[r_rptr];
            end
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/axi_wdata_slave.sv
// rtl/axi_wdata_slave.sv - AXI W-channel slave: burst FSM, beat counter, B response, buffered read port
module axi_wdata_slave
    import axi_wdata_slave_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_W-1:0]             S_WDATA,
    input  logic                          S_WVALID,
    input  logic                          S_WLAST,
    output logic                          S_WREADY,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [1:0]                    BRESP,
    input  logic                          RD_EN,
    output logic [DATA_W-1:0]             RD_DATA,
    output logic                          RD_VALID,
    output logic                          FIFO_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int            LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] MAX_FILL = LW'(FIFO_DEPTH - BURST_LEN);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic             r_armed;
    logic             r_rd_valid;

    logic             w_full;
    logic             w_empty;
    logic [LW-1:0]    w_level;
    logic             w_accept;
    logic             w_pop;
    logic [CNT_W:0]   w_cnt_p1;
    logic             w_is_nth;
    logic             w_room;

    assign S_WREADY   = (r_state == ST_RECV) && !w_full;
    assign w_accept   = S_WVALID && S_WREADY;
    assign w_pop      = RD_EN && !w_empty;
    assign w_cnt_p1   = {1'b0, r_cnt} + 1'b1;
    assign w_is_nth   = (w_cnt_p1 == (CNT_W+1)'(BURST_LEN));
    assign w_room     = (w_level <= MAX_FILL);
    assign BVALID     = r_bvalid;
    assign BRESP      = r_bresp;
    assign RD_VALID   = r_rd_valid;
    assign FIFO_EMPTY = w_empty;
    assign FIFO_LEVEL = w_level;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (S_WDATA),
        .dout  (RD_DATA),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // r_armed holds IDLE for one extra edge after reset so S_WREADY cannot rise on the first edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_armed    <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_armed    <= 1'b1;
            r_rd_valid <= w_pop;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && w_room) begin
                        r_state <= ST_RECV;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (w_accept) begin
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (S_WLAST) begin
                            r_state  <= ST_RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (w_is_nth && !r_err) ? RESP_OKAY : RESP_SLVERR;
                        end else if (w_is_nth) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (BREADY) begin
                        r_state  <= ST_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wdata_slave.sv
// tb/tb_axi_wdata_slave.sv - randomized bench for axi_wdata_slave against a queue-based reference model
module tb_axi_wdata_slave;

    localparam int DATA_W     = 32;
    localparam int BURST_LEN  = 256;
    localparam int FIFO_DEPTH = 512;
    localparam int LW         = 10;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [DATA_W-1:0] S_WDATA = '0;
    logic              S_WVALID = 1'b0;
    logic              S_WLAST = 1'b0;
    logic              S_WREADY;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [1:0]        BRESP;
    logic              RD_EN = 1'b0;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic              FIFO_EMPTY;
    logic [LW-1:0]     FIFO_LEVEL;

    always #5 clk = ~clk;

    axi_wdata_slave #(
        .DATA_W     (DATA_W),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .S_WDATA    (S_WDATA),
        .S_WVALID   (S_WVALID),
        .S_WLAST    (S_WLAST),
        .S_WREADY   (S_WREADY),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .BRESP      (BRESP),
        .RD_EN      (RD_EN),
        .RD_DATA    (RD_DATA),
        .RD_VALID   (RD_VALID),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] model_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, predict from the model, advance, compare read port and occupancy.
    task automatic tick(input logic wv, input logic [DATA_W-1:0] wd, input logic wl,
                        input logic re, input logic br, output logic acc, output logic hs);
        logic              exp_rv;
        logic [DATA_W-1:0] exp_rd;
        S_WVALID = wv;
        S_WDATA  = wd;
        S_WLAST  = wl;
        RD_EN    = re;
        BREADY   = br;
        #1;
        acc    = wv && S_WREADY;
        hs     = BVALID && br;
        exp_rv = re && (model_q.size() > 0);
        exp_rd = '0;
        if (exp_rv) exp_rd = model_q.pop_front();
        if (acc) model_q.push_back(wd);
        @(posedge clk);
        #1;
        chk("rd_valid", RD_VALID, exp_rv);
        if (exp_rv) chk("rd_data", RD_DATA, exp_rd);
        chk("level", FIFO_LEVEL, model_q.size());
        chk("empty", FIFO_EMPTY, model_q.size() == 0);
        if (model_q.size() == FIFO_DEPTH) chk("wready_full", S_WREADY, 1'b0);
    endtask

    task automatic idle(input int n, input logic re);
        logic a, h;
        for (int k = 0; k < n; k++) tick(1'b0, $urandom, 1'b0, re, 1'b0, a, h);
    endtask

    task automatic send_burst(input int n, input int gap_pct, input int rd_pct,
                              input bit with_last, output int accepted);
        logic a, h;
        int   waitc;
        accepted = 0;
        while (accepted < n) begin
            waitc = 0;
            do begin
                tick($urandom_range(99) >= gap_pct, $urandom, with_last && (accepted == n-1),
                     $urandom_range(99) < rd_pct, 1'b0, a, h);
                waitc++;
            end while (!a && waitc < 300);
            if (!a) begin
                chk("beat_accept_timeout", a, 1'b1);
                break;
            end
            accepted++;
        end
        S_WVALID = 1'b0;
        S_WLAST  = 1'b0;
    endtask

    task automatic respond(input logic [1:0] exp_resp, input int delay);
        logic a, h;
        chk("bvalid_up", BVALID, 1'b1);
        chk("bresp", BRESP, exp_resp);
        chk("wready_in_resp", S_WREADY, 1'b0);
        for (int k = 0; k < delay; k++) begin
            tick(1'b0, $urandom, 1'b0, 1'b0, 1'b0, a, h);
            chk("bvalid_hold", BVALID, 1'b1);
            chk("bresp_hold", BRESP, exp_resp);
            chk("wready_hold", S_WREADY, 1'b0);
        end
        tick(1'b0, $urandom, 1'b0, 1'b0, 1'b1, a, h);
        chk("b_handshake", h, 1'b1);
        chk("bvalid_drop", BVALID, 1'b0);
        BREADY = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (model_q.size() > 0 && budget < 2000) begin
            idle(1, $urandom_range(3) != 0);
            budget++;
        end
        chk("drain_done", model_q.size(), 0);
        idle(1, 1'b1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_wready", S_WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_bresp", BRESP, 2'b00);
        chk("rst_rd_valid", RD_VALID, 1'b0);
        chk("rst_rd_data", RD_DATA, '0);
        chk("rst_empty", FIFO_EMPTY, 1'b1);
        chk("rst_level", FIFO_LEVEL, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("wready_first_edge", S_WREADY, 1'b0);
    endtask

    function automatic logic [1:0] exp_bresp(input int beats);
        return (beats == BURST_LEN) ? 2'b00 : 2'b10;
    endfunction

    initial begin
        int n;
        int acc;
        #2;
        check_reset_outputs();
        release_reset();

        // nominal burst, WVALID held high
        send_burst(BURST_LEN, 0, 0, 1'b1, acc);
        chk("nominal_accepts", acc, BURST_LEN);
        chk("nominal_level", FIFO_LEVEL, BURST_LEN);
        respond(exp_bresp(acc), 0);
        drain();

        // short burst with gaps
        send_burst(10, 30, 0, 1'b1, acc);
        chk("short_level", FIFO_LEVEL, 10);
        respond(exp_bresp(acc), 1);
        drain();

        // overrun
        send_burst(260, 10, 0, 1'b1, acc);
        chk("overrun_accepts", acc, 260);
        respond(2'b10, 0);
        drain();

        // fill the FIFO with two bursts, no reads
        send_burst(BURST_LEN, 0, 0, 1'b1, acc);
        respond(2'b00, 0);
        send_burst(BURST_LEN, 20, 0, 1'b1, acc);
        respond(2'b00, 0);
        chk("full_level", FIFO_LEVEL, FIFO_DEPTH);
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b0);
            chk("full_wready_low", S_WREADY, 1'b0);
        end
        idle(1, 1'b1);
        chk("after_pop_level", FIFO_LEVEL, FIFO_DEPTH - 1);
        idle(3, 1'b0);
        chk("near_full_wready_low", S_WREADY, 1'b0);
        drain();

        // backpressure on B channel
        send_burst(7, 0, 0, 1'b1, acc);
        respond(2'b10, 5);
        drain();

        // random bursts with concurrent reads and random BREADY delay
        for (int b = 0; b < 6; b++) begin
            n = ($urandom_range(2) == 0) ? BURST_LEN : $urandom_range(270, 1);
            send_burst(n, $urandom_range(40), $urandom_range(50), 1'b1, acc);
            respond(exp_bresp(acc), $urandom_range(4));
            drain();
        end

        // reset in the middle of a burst, then a clean burst
        send_burst(100, 10, 0, 1'b0, acc);
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        model_q.delete();
        release_reset();
        send_burst(BURST_LEN, 25, 0, 1'b1, acc);
        chk("post_reset_level", FIFO_LEVEL, BURST_LEN);
        respond(exp_bresp(acc), 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
